mips_multicycle_ctrl: RTL

//   Control FSM for the multi-cycle MIPS core, successor to the single-cycle datapath control.

---
 rtl/mips_multicycle_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences each instruction through a shared
// req/ready memory port, flags a sticky bus timeout, and keeps perf counters.
module mips_multicycle_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned PERF_CNT_W     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [5:0]            i_opcode,
  input  logic [5:0]            i_funct,
  input  logic                  i_branch_taken,
  input  logic                  i_mem_ready,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic                  o_iord,
  output logic                  o_ir_write,
  output logic                  o_pc_write,
  output logic [1:0]            o_pc_src,
  output logic [1:0]            o_alu_src_b,
  output logic                  o_reg_write,
  output logic [1:0]            o_reg_dst,
  output logic                  o_mem_to_reg,
  output logic [3:0]            o_state,
  output logic                  o_instr_retired,
  output logic                  o_illegal_op,
  output logic                  o_bus_err,
  output logic [PERF_CNT_W-1:0] o_cycle_cnt,
  output logic [PERF_CNT_W-1:0] o_instr_cnt
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_FAULT     = 4'd11
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [WAIT_W-1:0]     r_wait;
  logic                  r_bus_err;
  logic [PERF_CNT_W-1:0] r_cycle_cnt;
  logic [PERF_CNT_W-1:0] r_instr_cnt;
  logic                  w_req;
  logic                  w_done;
  logic                  w_stall;
  logic                  w_timeout;
  logic                  w_retire;

  // Next-state and strobe decode from state, opcode and funct; reset forces strobes low.
  always_comb begin
    w_next          = r_state;
    w_req           = 1'b0;
    o_mem_we        = 1'b0;
    o_iord          = 1'b0;
    o_ir_write      = 1'b0;
    o_pc_write      = 1'b0;
    o_pc_src        = 2'd0;
    o_alu_src_b     = 2'd0;
    o_reg_write     = 1'b0;
    o_reg_dst       = 2'd0;
    o_mem_to_reg    = 1'b0;
    o_illegal_op    = 1'b0;
    w_retire        = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        case (i_opcode)
          6'h00: w_next = (i_funct == 6'h08 || i_funct == 6'h09) ? S_JUMP : S_EXEC_R;
          6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
          6'h28, 6'h29, 6'h2B: w_next = S_MEM_ADDR;
          6'h01, 6'h04, 6'h05, 6'h06, 6'h07: w_next = S_BRANCH;
          6'h02, 6'h03: w_next = S_JUMP;
          6'h08, 6'h09, 6'h0A, 6'h0B,
          6'h0C, 6'h0D, 6'h0E, 6'h0F: w_next = S_EXEC_I;
          default: begin
            o_illegal_op = 1'b1;
            w_retire     = 1'b1;
            w_next       = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        o_alu_src_b = 2'd2;
        // Opcode bit 3 separates stores (0x28..0x2B) from loads (0x20..0x25).
        w_next = i_opcode[3] ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        w_req  = 1'b1;
        o_iord = 1'b1;
        if (i_mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_req    = 1'b1;
        o_iord   = 1'b1;
        o_mem_we = 1'b1;
        if (i_mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXEC_R: begin
        o_reg_dst = 2'd1;
        w_next    = S_ALU_WB;
      end
      S_EXEC_I: begin
        o_alu_src_b = 2'd2;
        w_next      = S_ALU_WB;
      end
      S_ALU_WB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = (i_opcode == 6'h00) ? 2'd1 : 2'd0;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        o_pc_src   = 2'd1;
        o_pc_write = i_branch_taken;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_JUMP: begin
        o_pc_write = 1'b1;
        w_retire   = 1'b1;
        w_next     = S_FETCH;
        if (i_opcode == 6'h02) begin
          o_pc_src = 2'd2;
        end else if (i_opcode == 6'h03) begin
          o_pc_src    = 2'd2;
          o_reg_write = 1'b1;
          o_reg_dst   = 2'd2;
        end else begin
          o_pc_src = 2'd3;
          if (i_funct == 6'h09) begin
            o_reg_write = 1'b1;
            o_reg_dst   = 2'd1;
          end
        end
      end
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FETCH;
    endcase

    w_done    = w_req && i_mem_ready;
    w_stall   = w_req && !i_mem_ready;
    w_timeout = w_stall && (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));
    if (w_timeout) w_next = S_FAULT;

    if (i_rst) begin
      w_req        = 1'b0;
      o_mem_we     = 1'b0;
      o_iord       = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_pc_src     = 2'd0;
      o_alu_src_b  = 2'd0;
      o_reg_write  = 1'b0;
      o_reg_dst    = 2'd0;
      o_mem_to_reg = 1'b0;
      o_illegal_op = 1'b0;
      w_retire     = 1'b0;
    end
    o_mem_req       = w_req;
    o_instr_retired = w_retire;
  end

  // State, wait counter, sticky fault and perf counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_FETCH;
      r_wait      <= '0;
      r_bus_err   <= 1'b0;
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_timeout) r_bus_err <= 1'b1;
      if (w_next != r_state || w_done) r_wait <= '0;
      else if (w_stall)                r_wait <= r_wait + WAIT_W'(1);
      if (r_state != S_FAULT) r_cycle_cnt <= r_cycle_cnt + PERF_CNT_W'(1);
      if (w_retire)           r_instr_cnt <= r_instr_cnt + PERF_CNT_W'(1);
    end
  end

  assign o_state     = r_state;
  assign o_bus_err   = r_bus_err;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_instr_cnt = r_instr_cnt;

endmodule
